cva6_obi_data_arbiter: RTL and testbench
========================================

Name: cva6_obi_data_arbiter

Overview:
- Shares one OBI data-bus master port between the four CVA6 data-side requesters: 0=PTW, 1=AMO, 2=Load, 3=Store.
- Arbitrates the address phase and enforces OBI request stability.
- Records the source of every accepted transaction in an order FIFO and routes in-order responses back to that source.
- Serialises atomic (ATOP) transactions against all other traffic; sits between the load/store unit, the PTW and the memory interconnect.

Parameters:
- AddrWidth, 56, address width (PLEN).
- DataWidth, 64, data width (XLEN).
- MaxOutstanding, 4, order-FIFO depth (power of 2, >=2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_i  in  4  per-requester request
- gnt_o  out  4  per-requester grant
- addr_i  in  4*AddrWidth  packed requester addresses
- we_i  in  4  write enable
- be_i  in  4*DataWidth/8  byte enables
- wdata_i  in  4*DataWidth  write data
- atop_i  in  4*6  atomic opcode; 0 = plain access
- rvalid_o  out  4  per-requester response valid
- rready_i  in  4  per-requester response ready
- rdata_o  out  DataWidth  response data, broadcast to all requesters
- err_o  out  1  response error, broadcast to all requesters
- obi_req_o  out  1  master request
- obi_gnt_i  in  1  master grant
- obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o, obi_atop_o  out  as above  selected request fields
- obi_rvalid_i  in  1  master response valid
- obi_rready_o  out  1  master response ready
- obi_rdata_i  in  DataWidth  master response data
- obi_err_i  in  1  master response error
- spurious_o  out  1  one-cycle pulse on a response received with the FIFO empty

Behaviour:
- Reset:
  - Outputs: all gnt_o, rvalid_o, obi_req_o, spurious_o = 0; obi_rready_o = 1.
  - Internal state: FIFO empty, count = 0, FSM = ARB, RR pointer = 0.
  - A reset asserted mid-transaction abandons all pending entries; later responses are treated as spurious.
- Address path is combinational (0-cycle latency):
  - obi_req_o and the obi_* fields come from the selected requester.
  - gnt_o[k] = obi_req_o & obi_gnt_i & (sel == k).
- Selection is fixed priority, lowest index wins; see the optional feature for round-robin.
- Eligibility:
  - A requester is eligible only when the FIFO is not full. There is no full-with-pop bypass.
  - A plain request is eligible only in ARB or HOLD.
- FSM:
  - ARB: select among eligible requesters.
    - Winner has atop == 0 and no grant -> latch sel, go to HOLD.
    - Winner has atop != 0 and count > 0 -> latch sel, go to DRAIN. obi_req_o = 0 while in DRAIN.
    - Winner has atop != 0 and count == 0 -> issue the request.
      - Granted -> go to AMO_RSP.
      - Not granted -> go to HOLD, with the atomic flag remembered.
  - HOLD: obi_req_o = 1 from the latched sel.
    - Other requesters are not considered; sel is frozen until granted.
    - On grant -> AMO_RSP if the atomic flag is set, else ARB.
    - If the latched requester drops req_i (protocol violation), return to ARB. No assertion.
  - DRAIN: no requests are issued. Once count == 0, issue the latched ATOP request; on grant -> AMO_RSP, else HOLD.
  - AMO_RSP: no grants. On the ATOP response handshake -> ARB.
- Order FIFO:
  - Push sel on obi_req_o & obi_gnt_i.
  - Pop on obi_rvalid_i & obi_rready_o while count > 0.
  - Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo MaxOutstanding.
- Response path (combinational):
  - rvalid_o[k] = obi_rvalid_i & (count > 0) & (head == k).
  - obi_rready_o = rready_i[head] when count > 0, else 1.
  - rdata_o = obi_rdata_i and err_o = obi_err_i at all times.
- Spurious response: obi_rvalid_i with count == 0 is accepted (rready = 1) and dropped; spurious_o pulses for 1 cycle.

Optional Feature:
- Macro: CVA6_OBI_ARB_RR_EN.
- Defined: selection in ARB is round-robin. The search starts at rr_ptr; after each grant rr_ptr = granted index + 1, mod 4. HOLD and DRAIN still freeze the selection.
- Undefined: fixed priority, PTW > AMO > Load > Store, and no rr_ptr state.

Test Plan:
- Load and store request in the same cycle, obi_gnt_i = 1, no RR -> gnt_o = 4'b0100 that cycle; the store is granted the next cycle; responses arrive rvalid_o = 0100 then 1000 in order.
- Load request with obi_gnt_i held low for 3 cycles while PTW asserts at cycle 1 -> obi_addr_o stays at the load address, gnt_o[2] is asserted at cycle 3, and PTW is granted afterwards.
- Two loads outstanding, then an AMO with atop = 6'h2B -> obi_req_o = 0 until both responses pop; the AMO is issued with count == 0; the store is blocked until the AMO response.
- 4 loads granted with no responses (MaxOutstanding = 4) -> the 5th request sees gnt_o = 0 until one response pops.
- obi_rvalid_i = 1 with the FIFO empty -> spurious_o = 1 for one cycle, all rvalid_o = 0.
- With RR enabled, all four requesting continuously and gnt_i = 1 -> grant order 0, 1, 2, 3, 0. Reset asserted mid-sequence -> count = 0 and all outputs at reset values the next cycle.

Source files
------------

// File: rtl/cva6_obi_data_arbiter_if.sv
// Bus bundle for cva6_obi_data_arbiter: four requester ports plus the shared OBI master port.
// Modport slave is the arbiter's view; master is the environment (requesters and memory).
interface cva6_obi_data_arbiter_if #(
  parameter int unsigned AddrWidth = 56,
  parameter int unsigned DataWidth = 64
);
  logic [3:0]               req_i;
  logic [3:0]               gnt_o;
  logic [4*AddrWidth-1:0]   addr_i;
  logic [3:0]               we_i;
  logic [4*DataWidth/8-1:0] be_i;
  logic [4*DataWidth-1:0]   wdata_i;
  logic [4*6-1:0]           atop_i;
  logic [3:0]               rvalid_o;
  logic [3:0]               rready_i;
  logic [DataWidth-1:0]     rdata_o;
  logic                     err_o;
  logic                     obi_req_o;
  logic                     obi_gnt_i;
  logic [AddrWidth-1:0]     obi_addr_o;
  logic                     obi_we_o;
  logic [DataWidth/8-1:0]   obi_be_o;
  logic [DataWidth-1:0]     obi_wdata_o;
  logic [5:0]               obi_atop_o;
  logic                     obi_rvalid_i;
  logic                     obi_rready_o;
  logic [DataWidth-1:0]     obi_rdata_i;
  logic                     obi_err_i;
  logic                     spurious_o;

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i, atop_i, rready_i,
           obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
    output gnt_o, rvalid_o, rdata_o, err_o,
           obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o, obi_atop_o,
           obi_rready_o, spurious_o
  );

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i, atop_i, rready_i,
           obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
    input  gnt_o, rvalid_o, rdata_o, err_o,
           obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o, obi_atop_o,
           obi_rready_o, spurious_o
  );
endinterface

// File: rtl/cva6_obi_data_arbiter.sv
// Shares one OBI data master between PTW(0), AMO(1), Load(2), Store(3) with in-order response routing.
// Define CVA6_OBI_ARB_RR_EN for round-robin selection; default is fixed priority, lowest index wins.
module cva6_obi_data_arbiter #(
  parameter int unsigned AddrWidth      = 56,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 4
) (
  input logic clk_i,
  input logic rst_i,
  cva6_obi_data_arbiter_if.slave bus
);
  localparam int unsigned PtrW  = $clog2(MaxOutstanding);
  localparam int unsigned StrbW = DataWidth / 8;

  typedef enum logic [1:0] {ARB, HOLD, DRAIN, AMO_RSP} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sel_q, sel_d, sel;
  logic            atomic_q, atomic_d;
  logic [1:0]      winner, scan, head;
  logic            win_valid, req_out;
  logic            push, pop, full, empty;
  logic [3:0]      eligible;
  logic [1:0]      order_q [MaxOutstanding];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q;

  logic [AddrWidth-1:0] addr  [4];
  logic [StrbW-1:0]     be    [4];
  logic [DataWidth-1:0] wdata [4];
  logic [5:0]           atop  [4];

  for (genvar k = 0; k < 4; k++) begin : g_unpack
    assign addr[k]  = bus.addr_i[k*AddrWidth +: AddrWidth];
    assign be[k]    = bus.be_i[k*StrbW +: StrbW];
    assign wdata[k] = bus.wdata_i[k*DataWidth +: DataWidth];
    assign atop[k]  = bus.atop_i[k*6 +: 6];
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == (PtrW+1)'(MaxOutstanding));
  assign eligible = bus.req_i & {4{~full}};

`ifdef CVA6_OBI_ARB_RR_EN
  logic [1:0] rr_ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
    end else if (push) begin
      rr_ptr_q <= sel + 2'd1;
    end
  end
`endif

  // First eligible index in search order wins.
  always_comb begin
    win_valid = 1'b0;
    winner    = '0;
    scan      = '0;
    for (int unsigned i = 0; i < 4; i++) begin
`ifdef CVA6_OBI_ARB_RR_EN
      scan = rr_ptr_q + 2'(i);
`else
      scan = 2'(i);
`endif
      if (!win_valid && eligible[scan]) begin
        win_valid = 1'b1;
        winner    = scan;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    atomic_d = atomic_q;
    sel      = sel_q;
    req_out  = 1'b0;
    unique case (state_q)
      ARB: begin
        sel = winner;
        if (win_valid) begin
          sel_d = winner;
          if (atop[winner] == '0) begin
            req_out  = 1'b1;
            atomic_d = 1'b0;
            if (!bus.obi_gnt_i) state_d = HOLD;
          end else if (!empty) begin
            atomic_d = 1'b1;
            state_d  = DRAIN;
          end else begin
            req_out  = 1'b1;
            atomic_d = 1'b1;
            state_d  = bus.obi_gnt_i ? AMO_RSP : HOLD;
          end
        end
      end
      HOLD: begin
        if (!bus.req_i[sel_q]) begin
          state_d = ARB;
        end else begin
          req_out = 1'b1;
          if (bus.obi_gnt_i) state_d = atomic_q ? AMO_RSP : ARB;
        end
      end
      DRAIN: begin
        if (empty) begin
          if (!bus.req_i[sel_q]) begin
            state_d = ARB;
          end else begin
            req_out = 1'b1;
            state_d = bus.obi_gnt_i ? AMO_RSP : HOLD;
          end
        end
      end
      AMO_RSP: begin
        if (pop) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ARB;
      sel_q    <= '0;
      atomic_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      atomic_q <= atomic_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        order_q[wptr_q] <= sel;
        wptr_q          <= wptr_q + PtrW'(1);
      end
      if (pop) rptr_q <= rptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Combinational outputs are forced to their idle values while reset is held.
  assign bus.obi_req_o   = req_out & ~rst_i;
  assign push            = bus.obi_req_o & bus.obi_gnt_i;
  assign bus.gnt_o       = push ? (4'b0001 << sel) : 4'b0000;
  assign bus.obi_addr_o  = addr[sel];
  assign bus.obi_we_o    = bus.we_i[sel];
  assign bus.obi_be_o    = be[sel];
  assign bus.obi_wdata_o = wdata[sel];
  assign bus.obi_atop_o  = atop[sel];

  assign head             = order_q[rptr_q];
  assign bus.obi_rready_o = rst_i | empty | bus.rready_i[head];
  assign pop              = bus.obi_rvalid_i & bus.obi_rready_o & ~empty;
  assign bus.rvalid_o     = (bus.obi_rvalid_i & ~empty & ~rst_i) ? (4'b0001 << head) : 4'b0000;
  assign bus.spurious_o   = bus.obi_rvalid_i & empty & ~rst_i;
  assign bus.rdata_o      = bus.obi_rdata_i;
  assign bus.err_o        = bus.obi_err_i;
endmodule

// File: tb/tb_cva6_obi_data_arbiter.sv
// Bench for cva6_obi_data_arbiter: directed vectors with literal checks plus a per-cycle
// queue-based reference model of arbitration, ordering and response routing.
module tb_cva6_obi_data_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  cva6_obi_data_arbiter_if #(.AddrWidth(56), .DataWidth(64)) bus ();

  cva6_obi_data_arbiter #(
    .AddrWidth(56),
    .DataWidth(64),
    .MaxOutstanding(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [55:0] a_addr [4];
  logic        a_we   [4];
  logic [7:0]  a_be   [4];
  logic [63:0] a_wd   [4];
  logic [5:0]  a_atop [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic pack();
    for (int k = 0; k < 4; k++) begin
      bus.addr_i[k*56 +: 56] = a_addr[k];
      bus.we_i[k]            = a_we[k];
      bus.be_i[k*8 +: 8]     = a_be[k];
      bus.wdata_i[k*64 +: 64] = a_wd[k];
      bus.atop_i[k*6 +: 6]   = a_atop[k];
    end
  endtask

  task automatic set_atop(input int k, input logic [5:0] v);
    a_atop[k] = v;
    pack();
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Reference model: outstanding sources in a queue, plus which requester (if any) owns the bus.
  int order_q[$];
  int lock_src  = -1;
  bit lock_amo  = 1'b0;
  int drain_src = -1;
  bit amo_busy  = 1'b0;
  int rr        = 0;

  function automatic int pick(input logic [3:0] c, input int start);
    for (int i = 0; i < 4; i++)
      if (c[(start + i) % 4]) return (start + i) % 4;
    return -1;
  endfunction

  always @(negedge clk) begin : model
    logic [3:0] e_gnt, e_rv, cand;
    logic       e_req, e_rdy, e_sp;
    int         who, w, h, n_lock, n_drain;
    bit         who_amo, n_lamo, n_amo, do_pop, full;
    e_gnt = '0; e_rv = '0; e_req = 1'b0; e_sp = 1'b0; e_rdy = 1'b1;
    who = -1; who_amo = 1'b0; do_pop = 1'b0;
    if (rst) begin
      chk("m_rst_out", {53'd0, bus.gnt_o, bus.rvalid_o, bus.obi_req_o, bus.spurious_o, bus.obi_rready_o},
          64'h001);
      order_q.delete();
      lock_src = -1; lock_amo = 1'b0; drain_src = -1; amo_busy = 1'b0; rr = 0;
    end else begin
      full    = (order_q.size() == 4);
      n_lock  = lock_src; n_lamo = lock_amo; n_drain = drain_src; n_amo = amo_busy;
      if (order_q.size() == 0) begin
        e_sp = bus.obi_rvalid_i;
      end else begin
        h     = order_q[0];
        e_rdy = bus.rready_i[h];
        if (bus.obi_rvalid_i) e_rv[h] = 1'b1;
        do_pop = bus.obi_rvalid_i && e_rdy;
      end
      if (lock_src >= 0) begin
        n_lock = -1;
        if (bus.req_i[lock_src]) begin who = lock_src; who_amo = lock_amo; end
      end else if (drain_src >= 0) begin
        if (order_q.size() == 0) begin
          n_drain = -1;
          if (bus.req_i[drain_src]) begin who = drain_src; who_amo = 1'b1; end
        end
      end else if (!amo_busy) begin
        cand = full ? 4'b0000 : bus.req_i;
`ifdef CVA6_OBI_ARB_RR_EN
        w = pick(cand, rr);
`else
        w = pick(cand, 0);
`endif
        if (w >= 0) begin
          if (a_atop[w] == 6'd0) who = w;
          else if (order_q.size() > 0) n_drain = w;
          else begin who = w; who_amo = 1'b1; end
        end
      end
      if (do_pop) begin
        void'(order_q.pop_front());
        if (amo_busy) n_amo = 1'b0;
      end
      if (who >= 0) begin
        e_req = 1'b1;
        if (bus.obi_gnt_i) begin
          e_gnt[who] = 1'b1;
          order_q.push_back(who);
          n_amo = who_amo;
          rr    = (who + 1) % 4;
        end else begin
          n_lock = who; n_lamo = who_amo;
        end
      end
      chk("m_gnt", 64'(bus.gnt_o), 64'(e_gnt));
      chk("m_obi_req", 64'(bus.obi_req_o), 64'(e_req));
      chk("m_rvalid", 64'(bus.rvalid_o), 64'(e_rv));
      chk("m_obi_rready", 64'(bus.obi_rready_o), 64'(e_rdy));
      chk("m_spurious", 64'(bus.spurious_o), 64'(e_sp));
      chk("m_rdata", bus.rdata_o, bus.obi_rdata_i);
      chk("m_err", 64'(bus.err_o), 64'(bus.obi_err_i));
      if (e_req) begin
        chk("m_addr", 64'(bus.obi_addr_o), 64'(a_addr[who]));
        chk("m_fields", {bus.obi_we_o, bus.obi_be_o, bus.obi_atop_o},
            {a_we[who], a_be[who], a_atop[who]});
        chk("m_wdata", bus.obi_wdata_o, a_wd[who]);
      end
      lock_src = n_lock; lock_amo = n_lamo; drain_src = n_drain; amo_busy = n_amo;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  logic [3:0] exp_g [5];

  initial begin
    for (int k = 0; k < 4; k++) begin
      a_addr[k] = 56'hA0_0000 | (56'(k) << 8);
      a_we[k]   = (k == 3);
      a_be[k]   = 8'hF0 | 8'(k);
      a_wd[k]   = 64'hD00D_0000_0000_0000 | 64'(k);
      a_atop[k] = 6'd0;
    end
    pack();
    rst = 1'b1;
    bus.req_i = 4'hF; bus.rready_i = 4'hF; bus.obi_gnt_i = 1'b1;
    bus.obi_rvalid_i = 1'b1; bus.obi_rdata_i = 64'h0; bus.obi_err_i = 1'b0;

    // Reset: everything idle even with all inputs active.
    settle();
    chk("rst_gnt", 64'(bus.gnt_o), 64'h0);
    chk("rst_obi_req", 64'(bus.obi_req_o), 64'h0);
    chk("rst_spurious", 64'(bus.spurious_o), 64'h0);
    chk("rst_rready", 64'(bus.obi_rready_o), 64'h1);
    adv();
    rst = 1'b0; bus.req_i = 4'h0; bus.obi_rvalid_i = 1'b0;

    // Load and store together: load first, then store; responses in order.
    bus.req_i = 4'b1100; bus.obi_gnt_i = 1'b1;
    settle(); chk("s1_gnt_load", 64'(bus.gnt_o), 64'b0100); adv();
    bus.req_i = 4'b1000;
    settle(); chk("s1_gnt_store", 64'(bus.gnt_o), 64'b1000); adv();
    bus.req_i = 4'b0000; bus.obi_gnt_i = 1'b0; bus.obi_rvalid_i = 1'b1; bus.obi_rdata_i = 64'hAAAA;
    settle(); chk("s1_rv_load", 64'(bus.rvalid_o), 64'b0100); chk("s1_rdata", bus.rdata_o, 64'hAAAA); adv();
    bus.obi_rdata_i = 64'hBBBB; bus.obi_err_i = 1'b1;
    settle(); chk("s1_rv_store", 64'(bus.rvalid_o), 64'b1000); chk("s1_err", 64'(bus.err_o), 64'h1); adv();
    bus.obi_rvalid_i = 1'b0; bus.obi_err_i = 1'b0;

    // Load stalled three cycles; PTW arrives meanwhile but cannot steal the held request.
    bus.req_i = 4'b0100;
    settle(); chk("s2_req_held", 64'(bus.obi_req_o), 64'h1); adv();
    bus.req_i = 4'b0101;
    settle(); chk("s2_addr_c1", 64'(bus.obi_addr_o), 64'hA0_0200); adv();
    settle(); chk("s2_addr_c2", 64'(bus.obi_addr_o), 64'hA0_0200); adv();
    bus.obi_gnt_i = 1'b1;
    settle(); chk("s2_gnt_load", 64'(bus.gnt_o), 64'b0100); adv();
    bus.req_i = 4'b0001;
    settle(); chk("s2_gnt_ptw", 64'(bus.gnt_o), 64'b0001); adv();
    bus.req_i = 4'b0000; bus.obi_gnt_i = 1'b0; bus.obi_rvalid_i = 1'b1;
    settle(); chk("s2_rv_load", 64'(bus.rvalid_o), 64'b0100); adv();
    settle(); chk("s2_rv_ptw", 64'(bus.rvalid_o), 64'b0001); adv();
    bus.obi_rvalid_i = 1'b0;

    // Two loads outstanding, then an AMO: drain, issue alone, store blocked until AMO response.
    bus.req_i = 4'b0100; bus.obi_gnt_i = 1'b1;
    settle(); adv();
    settle(); adv();
    bus.req_i = 4'b0010; set_atop(1, 6'h2B);
    settle(); chk("s3_drain0", 64'(bus.obi_req_o), 64'h0); adv();
    bus.req_i = 4'b1010; bus.obi_rvalid_i = 1'b1;
    settle(); chk("s3_drain1", 64'(bus.obi_req_o), 64'h0); chk("s3_pop1", 64'(bus.rvalid_o), 64'b0100); adv();
    settle(); chk("s3_drain2", 64'(bus.obi_req_o), 64'h0); adv();
    bus.obi_rvalid_i = 1'b0;
    settle(); chk("s3_gnt_amo", 64'(bus.gnt_o), 64'b0010); chk("s3_atop", 64'(bus.obi_atop_o), 64'h2B); adv();
    bus.req_i = 4'b1000;
    settle(); chk("s3_store_blk0", 64'(bus.gnt_o), 64'h0); adv();
    settle(); chk("s3_store_blk1", 64'(bus.obi_req_o), 64'h0); adv();
    bus.obi_rvalid_i = 1'b1;
    settle(); chk("s3_rv_amo", 64'(bus.rvalid_o), 64'b0010); chk("s3_store_blk2", 64'(bus.gnt_o), 64'h0); adv();
    bus.obi_rvalid_i = 1'b0;
    settle(); chk("s3_gnt_store", 64'(bus.gnt_o), 64'b1000); adv();
    bus.req_i = 4'b0000; bus.obi_rvalid_i = 1'b1; set_atop(1, 6'h00);
    settle(); chk("s3_rv_store", 64'(bus.rvalid_o), 64'b1000); adv();
    bus.obi_rvalid_i = 1'b0;

    // Fill the order FIFO; the fifth request waits for a pop, with no same-cycle bypass.
    bus.req_i = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      settle(); chk("s4_fill", 64'(bus.gnt_o), 64'b0100); adv();
    end
    settle(); chk("s4_full", 64'(bus.gnt_o), 64'h0); adv();
    bus.obi_rvalid_i = 1'b1; bus.rready_i = 4'b1011;
    settle(); chk("s4_backpressure", 64'(bus.obi_rready_o), 64'h0); adv();
    bus.rready_i = 4'hF;
    settle(); chk("s4_no_bypass", 64'(bus.gnt_o), 64'h0); adv();
    bus.obi_rvalid_i = 1'b0;
    settle(); chk("s4_refill", 64'(bus.gnt_o), 64'b0100); adv();
    bus.req_i = 4'b0000; bus.obi_rvalid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle(); chk("s4_drain", 64'(bus.rvalid_o), 64'b0100); adv();
    end

    // Response with nothing outstanding.
    settle(); chk("s5_spurious", 64'(bus.spurious_o), 64'h1); chk("s5_no_rv", 64'(bus.rvalid_o), 64'h0); adv();
    bus.obi_rvalid_i = 1'b0;
    settle(); chk("s5_pulse_end", 64'(bus.spurious_o), 64'h0); adv();

    // Held requester withdraws: the hold is released and PTW wins afterwards.
    bus.req_i = 4'b0100; bus.obi_gnt_i = 1'b0;
    settle(); adv();
    bus.req_i = 4'b0001;
    settle(); chk("s6_release", 64'(bus.obi_req_o), 64'h0); adv();
    bus.obi_gnt_i = 1'b1;
    settle(); chk("s6_gnt_ptw", 64'(bus.gnt_o), 64'b0001); adv();
    bus.req_i = 4'b0000; bus.obi_rvalid_i = 1'b1;
    settle(); chk("s6_rv_ptw", 64'(bus.rvalid_o), 64'b0001); adv();
    bus.obi_rvalid_i = 1'b0;

    // All four requesting continuously from a fresh reset, then reset mid-sequence.
    rst = 1'b1;
    settle(); adv();
    rst = 1'b0; bus.req_i = 4'hF; bus.obi_gnt_i = 1'b1;
`ifdef CVA6_OBI_ARB_RR_EN
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
`else
    for (int i = 0; i < 5; i++) exp_g[i] = 4'b0001;
`endif
    for (int i = 0; i < 5; i++) begin
      if (i == 1) bus.obi_rvalid_i = 1'b1;
      settle(); chk("s7_order", 64'(bus.gnt_o), 64'(exp_g[i])); adv();
    end
    rst = 1'b1;
    settle();
    chk("s7_rst_gnt", 64'(bus.gnt_o), 64'h0);
    chk("s7_rst_rv", 64'(bus.rvalid_o), 64'h0);
    chk("s7_rst_req", 64'(bus.obi_req_o), 64'h0);
    adv();
    rst = 1'b0; bus.req_i = 4'b0000; bus.obi_gnt_i = 1'b0;
    settle(); chk("s7_abandoned", 64'(bus.spurious_o), 64'h1); chk("s7_abandoned_rv", 64'(bus.rvalid_o), 64'h0); adv();
    bus.obi_rvalid_i = 1'b0;
    settle(); adv();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
